// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Both sides import this package so that they agree on one opcode table.
//   - ALU_* : 4-bit ALUOperation opcode constants
//   - alu_state_t : execute-unit FSM state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SQU = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SQ   = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    // True when the opcode is handled by the iterative squarer.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_SQU);
    endfunction

endpackage

// File: rtl/alu_squarer.sv
// alu_squarer
// Iterative shift-add squarer. One partial product is folded into the
// accumulator per step, so a full square takes WIDTH steps.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   load    : clear the accumulator and load A as multiplicand and multiplier
//   step    : perform one shift-add iteration (ignored once finished)
//   A       : operand to square (sampled on load)
//   product : full 2*WIDTH-bit accumulator
//   last    : high once all WIDTH iterations have completed
module alu_squarer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     A,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [CW-1:0]      count;
    logic               finished;

    // Once 'finished' is set the accumulator is frozen, so the FSM may take
    // an extra cycle to pick up the product without disturbing it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            count        <= '0;
            finished     <= 1'b0;
        end else if (load) begin
            acc          <= '0;
            multiplicand <= {{WIDTH{1'b0}}, A};
            multiplier   <= A;
            count        <= '0;
            finished     <= 1'b0;
        end else if (step && !finished) begin
            if (multiplier[0]) begin
                acc <= acc + multiplicand;
            end
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            if (count == COUNT_LAST) begin
                count    <= '0;
                finished <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign product = acc;
    assign last    = finished;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage ALU with a start/busy/done handshake. Logic ops, ADD and MOV
// complete through a single EXEC cycle; SQU runs on the iterative squarer.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   start        : request, sampled only while idle
//   ALUOperation : opcode from alu_pkg
//   A, B         : operands (latched on the accepting edge)
//   busy         : high from the accepting edge through the done cycle
//   done         : one-cycle pulse when the result becomes valid
//   ALUResult    : registered result, held until the next done
//   Zero         : ALUResult == 0
//   Overflow     : ADD signed overflow or SQU truncation
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        ALUOperation,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  ALUResult,
    output logic              Zero,
    output logic              Overflow
);

    alu_state_t          state;
    logic [3:0]          op_code;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;

    logic [WIDTH-1:0]    exec_result;
    logic                exec_ovf;
    logic [WIDTH-1:0]    sum;

    logic                accept;
    logic                sq_load;
    logic                sq_step;
    logic [2*WIDTH-1:0]  sq_product;
    logic                sq_last;

    assign accept  = (state == ST_IDLE) && start;
    assign sq_load = accept && is_multicycle(ALUOperation);
    assign sq_step = (state == ST_SQ);

    alu_squarer #(.WIDTH(WIDTH)) u_squarer (
        .clk     (clk),
        .reset   (reset),
        .load    (sq_load),
        .step    (sq_step),
        .A       (A),
        .product (sq_product),
        .last    (sq_last)
    );

    // Single-cycle datapath, fed only from the latched operands so that
    // input changes after acceptance cannot leak into the result.
    always_comb begin
        exec_result = '0;
        exec_ovf    = 1'b0;
        sum         = op_a + op_b;
        case (op_code)
            ALU_AND: exec_result = op_a & op_b;
            ALU_OR:  exec_result = op_a | op_b;
            ALU_NOR: exec_result = ~(op_a | op_b);
            ALU_ADD: begin
                exec_result = sum;
                exec_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_MOV: exec_result = op_b;
            default: begin
                exec_result = '0;
                exec_ovf    = 1'b0;
            end
        endcase
    end

    // Control FSM and output registers. Results are only written on the
    // transition into DONE so they stay stable between operations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_code   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_code <= ALUOperation;
                        op_a    <= A;
                        op_b    <= B;
                        busy    <= 1'b1;
                        state   <= is_multicycle(ALUOperation) ? ST_SQ : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    ALUResult <= exec_result;
                    Zero      <= (exec_result == '0);
                    Overflow  <= exec_ovf;
                    done      <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_SQ: begin
                    // The squarer freezes after its final step; the product
                    // is captured on the following edge.
                    if (sq_last) begin
                        ALUResult <= sq_product[WIDTH-1:0];
                        Zero      <= (sq_product[WIDTH-1:0] == '0);
                        Overflow  <= |sq_product[2*WIDTH-1:WIDTH];
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed vector bench for alu_exec_unit (WIDTH=32) with hand-computed
// expected results, plus sequences for the SQU interrupt and reset cases.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic [3:0]        ALUOperation;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  ALUResult;
    logic              Zero;
    logic              Overflow;

    int checks;
    int fails;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .Overflow     (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        int          latency;
        int          busy_cycles;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one operation, optionally pulse a MOV start at a given edge count
    // after acceptance and/or assert start during the done cycle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int pulse_at,
                                 input bit poke_done, output int latency,
                                 output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        ALUOperation = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        ALUOperation = ~op;
        A = ~a;
        B = ~b;
        latency = 0;
        busy_cycles = busy ? 1 : 0;
        checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
        while (!done && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
            start = (latency == pulse_at);
            ALUOperation = (latency == pulse_at) ? ALU_MOV : ~op;
            if (busy) busy_cycles++;
        end
        if (!done) begin
            fails++;
            checks++;
            $display("[TB] FAIL done_timeout: got no done after %0d edges, expected done", latency);
        end
        if (poke_done) begin
            start = 1'b1;
            ALUOperation = ALU_ADD;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy) busy_cycles++;
        checkOutput("busy_low_after_done", {63'd0, busy}, 64'd0);
        checkOutput("done_single_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int lat;
        int bc;
        bit seen_done;
        bit seen_busy;

        checks = 0;
        fails  = 0;

        vecs[0]  = '{ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1, 2};
        vecs[1]  = '{ALU_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0, 1, 2};
        vecs[2]  = '{ALU_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 2};
        vecs[3]  = '{ALU_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1, 2};
        vecs[4]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 2};
        vecs[5]  = '{ALU_ADD, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 1'b0, 1, 2};
        vecs[6]  = '{ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1, 2};
        vecs[7]  = '{ALU_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1, 2};
        vecs[8]  = '{ALU_SQU, 32'h0000_000C, 32'h0000_0000, 32'h0000_0090, 1'b0, 1'b0, 33, 34};
        vecs[9]  = '{ALU_SQU, 32'h0000_FFFF, 32'h1111_1111, 32'hFFFE_0001, 1'b0, 1'b0, 33, 34};
        vecs[10] = '{ALU_SQU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 33, 34};
        vecs[11] = '{ALU_MOV, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 2};
        vecs[12] = '{4'b1001, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0, 1, 2};
        vecs[13] = '{4'b0101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 2};

        reset = 1'b0;
        start = 1'b0;
        ALUOperation = '0;
        A = '0;
        B = '0;
        #12;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_result", {32'd0, ALUResult}, 64'd0);
        checkOutput("reset_zero", {63'd0, Zero}, 64'd1);
        checkOutput("reset_ovf", {63'd0, Overflow}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, -1, (i == 11), lat, bc);
            checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].latency));
            checkOutput($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].busy_cycles));
            checkOutput($sformatf("v%0d_result", i), {32'd0, ALUResult}, {32'd0, vecs[i].res});
            checkOutput($sformatf("v%0d_zero", i), {63'd0, Zero}, {63'd0, vecs[i].zero});
            checkOutput($sformatf("v%0d_ovf", i), {63'd0, Overflow}, {63'd0, vecs[i].ovf});
        end

        // SQU of 2^16 truncates to zero; a MOV start mid-square is ignored.
        applyStimulus(ALU_SQU, 32'h0001_0000, 32'h0, 5, 1'b0, lat, bc);
        checkOutput("squ_trunc_latency", 64'(lat), 64'd33);
        checkOutput("squ_trunc_result", {32'd0, ALUResult}, 64'd0);
        checkOutput("squ_trunc_zero", {63'd0, Zero}, 64'd1);
        checkOutput("squ_trunc_ovf", {63'd0, Overflow}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("squ_trunc_no_queued_op", {63'd0, busy}, 64'd0);

        // Leave a nonzero result so the reset check below is meaningful.
        applyStimulus(ALU_MOV, 32'h0, 32'hDEAD_BEEF, -1, 1'b0, lat, bc);
        checkOutput("pre_reset_result", {32'd0, ALUResult}, 64'hDEAD_BEEF);

        // Reset in the middle of a square of 100.
        @(negedge clk);
        start = 1'b1;
        ALUOperation = ALU_SQU;
        A = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midsq_reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("midsq_reset_done", {63'd0, done}, 64'd0);
        checkOutput("midsq_reset_result", {32'd0, ALUResult}, 64'd0);
        checkOutput("midsq_reset_zero", {63'd0, Zero}, 64'd1);
        checkOutput("midsq_reset_ovf", {63'd0, Overflow}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            seen_done |= done;
            seen_busy |= busy;
        end
        checkOutput("post_reset_no_done", {63'd0, seen_done}, 64'd0);
        checkOutput("post_reset_idle", {63'd0, seen_busy}, 64'd0);

        applyStimulus(ALU_SQU, 32'd3, 32'h0, -1, 1'b0, lat, bc);
        checkOutput("post_reset_squ_latency", 64'(lat), 64'd33);
        checkOutput("post_reset_squ_result", {32'd0, ALUResult}, 64'd9);
        checkOutput("post_reset_squ_ovf", {63'd0, Overflow}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
